// File: rtl/williams_bus_arbiter.sv
// Video/work RAM port arbiter: shares one memory port between video fetch,
// the 6809 CPU and the blitter, and runs the blitter's CPU halt handshake.
module williams_bus_arbiter #(
    parameter int unsigned VID_BURST_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_e_n,
    output logic        cpu_halt_n,
    input  logic        cpu_ba,
    input  logic        cpu_bs,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    input  logic        blt_halt,
    output logic        halt_ack,
    input  logic        blt_rd,
    input  logic        blt_wr,
    input  logic [15:0] blt_address,
    input  logic [7:0]  blt_wdata,
    input  logic [1:0]  blt_nibble_en,
    output logic        blt_ack,
    output logic [7:0]  blt_rdata,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic [1:0]  mem_nibble_en,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        OWN_CPU,
        OWN_WAIT,
        OWN_BLT
    } own_e;

    typedef enum logic {
        ACC_IDLE,
        ACC_BUSY
    } acc_e;

    typedef enum logic [1:0] {
        SRC_VID,
        SRC_CPU,
        SRC_BLT
    } src_e;

    localparam logic [3:0] BMAX = 4'(VID_BURST_MAX);

    own_e        own_q, own_d;
    acc_e        acc_q, acc_d;
    src_e        src_q, src_d;
    logic [3:0]  burst_q, burst_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [1:0]  mem_nib_q, mem_nib_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  blt_rdata_q, blt_rdata_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        vid_ack_q, vid_ack_d;
    logic        blt_ack_q, blt_ack_d;

    logic done;
    logic acc_free;
    logic cpu_elig;
    logic blt_elig;
    logic pick_nv;
    logic pick_vid;

    assign done     = (acc_q == ACC_BUSY) && mem_ready;
    assign acc_free = (acc_q == ACC_IDLE) || (done && (src_q != SRC_CPU));
    assign cpu_elig = cpu_req && (own_q == OWN_CPU);
    // blt_ack still high means the blitter has not advanced yet
    assign blt_elig = (blt_rd || blt_wr) && (own_q == OWN_BLT) && !blt_ack_q;
    assign pick_nv  = (acc_q == ACC_IDLE) && (cpu_elig || blt_elig)
                      && (!vid_req || (burst_q == BMAX));
    assign pick_vid = (acc_q == ACC_IDLE) && vid_req && !pick_nv;

    always_comb begin
        own_d = own_q;
        unique case (own_q)
            OWN_CPU: begin
                if (blt_halt) begin
                    own_d = OWN_WAIT;
                end
            end
            OWN_WAIT: begin
                if (en_e_n) begin
                    if (!blt_halt) begin
                        own_d = OWN_CPU;
                    end else if (cpu_ba && cpu_bs && acc_free) begin
                        own_d = OWN_BLT;
                    end
                end
            end
            OWN_BLT: begin
                if (en_e_n && !blt_halt && (acc_q == ACC_IDLE)) begin
                    own_d = OWN_CPU;
                end
            end
            default: own_d = OWN_CPU;
        endcase
    end

    always_comb begin
        acc_d       = acc_q;
        src_d       = src_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_nib_d   = mem_nib_q;
        rdata_d     = rdata_q;
        blt_rdata_d = blt_rdata_q;
        cpu_ack_d   = 1'b0;
        vid_ack_d   = 1'b0;
        blt_ack_d   = blt_ack_q && !en_e_n;
        unique case (acc_q)
            ACC_IDLE: begin
                unique case (1'b1)
                    pick_vid: begin
                        acc_d       = ACC_BUSY;
                        src_d       = SRC_VID;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = vid_addr;
                        mem_wdata_d = 8'h00;
                        mem_nib_d   = 2'b11;
                    end
                    pick_nv && cpu_elig: begin
                        acc_d       = ACC_BUSY;
                        src_d       = SRC_CPU;
                        mem_req_d   = 1'b1;
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                        mem_nib_d   = 2'b11;
                    end
                    pick_nv && blt_elig: begin
                        acc_d       = ACC_BUSY;
                        src_d       = SRC_BLT;
                        mem_req_d   = 1'b1;
                        mem_we_d    = blt_wr;
                        mem_addr_d  = blt_address;
                        mem_wdata_d = blt_wdata;
                        mem_nib_d   = blt_wr ? blt_nibble_en : 2'b11;
                    end
                    default: begin
                    end
                endcase
            end
            ACC_BUSY: begin
                if (mem_ready) begin
                    acc_d     = ACC_IDLE;
                    mem_req_d = 1'b0;
                    unique case (src_q)
                        SRC_VID: begin
                            rdata_d   = mem_rdata;
                            vid_ack_d = 1'b1;
                        end
                        SRC_CPU: begin
                            rdata_d   = mem_rdata;
                            cpu_ack_d = 1'b1;
                        end
                        SRC_BLT: begin
                            if (!mem_we_q) begin
                                blt_rdata_d = mem_rdata;
                            end
                            blt_ack_d = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            default: acc_d = ACC_IDLE;
        endcase
    end

    always_comb begin
        burst_d = burst_q;
        if (!vid_req || pick_nv) begin
            burst_d = 4'd0;
        end else if (pick_vid && (burst_q != BMAX)) begin
            burst_d = burst_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            own_q       <= OWN_CPU;
            acc_q       <= ACC_IDLE;
            src_q       <= SRC_VID;
            burst_q     <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            mem_nib_q   <= 2'b11;
            rdata_q     <= 8'h00;
            blt_rdata_q <= 8'h00;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            blt_ack_q   <= 1'b0;
        end else begin
            own_q       <= own_d;
            acc_q       <= acc_d;
            src_q       <= src_d;
            burst_q     <= burst_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_nib_q   <= mem_nib_d;
            rdata_q     <= rdata_d;
            blt_rdata_q <= blt_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_ack_q   <= vid_ack_d;
            blt_ack_q   <= blt_ack_d;
        end
    end

    assign cpu_halt_n    = (own_q == OWN_CPU);
    assign halt_ack      = (own_q == OWN_BLT);
    assign cpu_ack       = cpu_ack_q;
    assign vid_ack       = vid_ack_q;
    assign blt_ack       = blt_ack_q;
    assign blt_rdata     = blt_rdata_q;
    assign rdata         = rdata_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_nibble_en = mem_nib_q;

endmodule

// File: tb/tb_williams_bus_arbiter.sv
// Directed bench for williams_bus_arbiter: CPU, blitter and video paths,
// halt handshake, video burst cap and reset mid-access.
module tb_williams_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_e_n;
    logic        cpu_halt_n;
    logic        cpu_ba, cpu_bs, cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic        blt_halt, halt_ack, blt_rd, blt_wr;
    logic [15:0] blt_address;
    logic [7:0]  blt_wdata;
    logic [1:0]  blt_nibble_en;
    logic        blt_ack;
    logic [7:0]  blt_rdata;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ack;
    logic [7:0]  rdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [1:0]  mem_nibble_en;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;

    always #5 clk = ~clk;

    williams_bus_arbiter #(.VID_BURST_MAX(4)) dut (
        .clk(clk), .rst(rst), .en_e_n(en_e_n),
        .cpu_halt_n(cpu_halt_n), .cpu_ba(cpu_ba), .cpu_bs(cpu_bs),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .blt_halt(blt_halt), .halt_ack(halt_ack),
        .blt_rd(blt_rd), .blt_wr(blt_wr), .blt_address(blt_address),
        .blt_wdata(blt_wdata), .blt_nibble_en(blt_nibble_en),
        .blt_ack(blt_ack), .blt_rdata(blt_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_nibble_en(mem_nibble_en), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always @(posedge clk)
        if (mem_req && mem_ready && mem_we) wr_cnt++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wr0;
        logic [15:0] exp_addr [6];
        logic        exp_vid  [6];
        rst = 1'b1; en_e_n = 1'b0;
        cpu_ba = 1'b0; cpu_bs = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        blt_halt = 1'b0; blt_rd = 1'b0; blt_wr = 1'b0;
        blt_address = '0; blt_wdata = '0; blt_nibble_en = 2'b11;
        vid_req = 1'b0; vid_addr = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        tick(); tick();
        check("rst_halt_n", 32'(cpu_halt_n), 32'd1);
        check("rst_halt_ack", 32'(halt_ack), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_nib", 32'(mem_nibble_en), 32'd3);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;

        // CPU-only read
        cpu_req = 1'b1; cpu_addr = 16'h9800;
        tick();
        check("cpu_rd_req", 32'(mem_req), 32'd1);
        check("cpu_rd_addr", 32'(mem_addr), 32'h9800);
        check("cpu_rd_we", 32'(mem_we), 32'd0);
        check("cpu_rd_ack0", 32'(cpu_ack), 32'd0);
        mem_ready = 1'b1; mem_rdata = 8'h5A;
        tick();
        mem_ready = 1'b0;
        check("cpu_rd_ack", 32'(cpu_ack), 32'd1);
        check("cpu_rd_data", 32'(rdata), 32'h5A);
        check("cpu_rd_reqlo", 32'(mem_req), 32'd0);
        check("cpu_rd_halt_n", 32'(cpu_halt_n), 32'd1);
        cpu_req = 1'b0;
        tick();
        check("cpu_rd_ackpulse", 32'(cpu_ack), 32'd0);
        check("cpu_rd_noregrant", 32'(mem_req), 32'd0);

        // halt handshake
        blt_halt = 1'b1;
        tick();
        check("hs_halt_n", 32'(cpu_halt_n), 32'd0);
        check("hs_ack0", 32'(halt_ack), 32'd0);
        cpu_ba = 1'b1; cpu_bs = 1'b1;
        tick();
        check("hs_no_en", 32'(halt_ack), 32'd0);
        en_e_n = 1'b1;
        tick();
        en_e_n = 1'b0;
        check("hs_ack", 32'(halt_ack), 32'd1);

        // blitter write with nibble mask
        wr0 = wr_cnt;
        blt_wr = 1'b1; blt_address = 16'h1234;
        blt_wdata = 8'hF0; blt_nibble_en = 2'b10;
        tick();
        check("bw_req", 32'(mem_req), 32'd1);
        check("bw_we", 32'(mem_we), 32'd1);
        check("bw_nib", 32'(mem_nibble_en), 32'd2);
        check("bw_addr", 32'(mem_addr), 32'h1234);
        check("bw_wdata", 32'(mem_wdata), 32'hF0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("bw_ack", 32'(blt_ack), 32'd1);
        tick();
        check("bw_ack_hold", 32'(blt_ack), 32'd1);
        check("bw_no_dup", 32'(mem_req), 32'd0);
        en_e_n = 1'b1;
        tick();
        en_e_n = 1'b0; blt_wr = 1'b0;
        check("bw_ack_clr", 32'(blt_ack), 32'd0);
        check("bw_no_dup2", 32'(mem_req), 32'd0);
        tick();
        check("bw_one_write", 32'(wr_cnt - wr0), 32'd1);

        // blitter read
        blt_rd = 1'b1; blt_address = 16'h4000;
        tick();
        check("br_we", 32'(mem_we), 32'd0);
        check("br_nib", 32'(mem_nibble_en), 32'd3);
        mem_ready = 1'b1; mem_rdata = 8'hC3;
        tick();
        mem_ready = 1'b0;
        check("br_data", 32'(blt_rdata), 32'hC3);
        check("br_ack", 32'(blt_ack), 32'd1);
        en_e_n = 1'b1;
        tick();
        en_e_n = 1'b0; blt_rd = 1'b0;

        // release the bus
        blt_halt = 1'b0;
        tick();
        check("rel_wait_en", 32'(halt_ack), 32'd1);
        check("rel_wait_hn", 32'(cpu_halt_n), 32'd0);
        en_e_n = 1'b1;
        tick();
        en_e_n = 1'b0;
        check("rel_ack", 32'(halt_ack), 32'd0);
        check("rel_halt_n", 32'(cpu_halt_n), 32'd1);

        // video burst cap of 4: V,V,V,V,C,V
        exp_addr = '{16'h0100, 16'h0100, 16'h0100, 16'h0100,
                     16'h9000, 16'h0100};
        exp_vid  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vid_req = 1'b1; vid_addr = 16'h0100;
        cpu_req = 1'b1; cpu_addr = 16'h9000; cpu_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("burst_grant%0d", i), 32'(mem_addr),
                  32'(exp_addr[i]));
            mem_ready = 1'b1; mem_rdata = 8'(8'h10 + i);
            tick();
            mem_ready = 1'b0;
            if (exp_vid[i])
                check($sformatf("burst_vack%0d", i), 32'(vid_ack), 32'd1);
            else
                check($sformatf("burst_cack%0d", i), 32'(cpu_ack), 32'd1);
            check($sformatf("burst_rdata%0d", i), 32'(rdata),
                  32'(8'h10 + i));
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        tick();

        // halt during CPU write
        cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = 16'hA000; cpu_wdata = 8'h77;
        tick();
        check("hc_req", 32'(mem_req), 32'd1);
        check("hc_we", 32'(mem_we), 32'd1);
        blt_halt = 1'b1; en_e_n = 1'b1;
        tick();
        check("hc_halt_n", 32'(cpu_halt_n), 32'd0);
        check("hc_ack0", 32'(halt_ack), 32'd0);
        tick();
        check("hc_busy_noack", 32'(halt_ack), 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("hc_cpu_ack", 32'(cpu_ack), 32'd1);
        check("hc_ack_late", 32'(halt_ack), 32'd0);
        tick();
        check("hc_ack", 32'(halt_ack), 32'd1);
        check("hc_no_cpu", 32'(mem_req), 32'd0);
        tick();
        check("hc_no_cpu2", 32'(mem_req), 32'd0);
        cpu_req = 1'b0; blt_halt = 1'b0;
        tick();
        en_e_n = 1'b0;
        check("hc_rel", 32'(cpu_halt_n), 32'd1);

        // reset mid-access with halt pending
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1111;
        tick();
        check("rm_req", 32'(mem_req), 32'd1);
        blt_halt = 1'b1;
        tick();
        check("rm_halt_n0", 32'(cpu_halt_n), 32'd0);
        rst = 1'b1; blt_halt = 1'b0; cpu_req = 1'b0;
        tick();
        rst = 1'b0;
        check("rm_req0", 32'(mem_req), 32'd0);
        check("rm_ack0", 32'(cpu_ack), 32'd0);
        check("rm_halt_n", 32'(cpu_halt_n), 32'd1);
        check("rm_halt_ack", 32'(halt_ack), 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("rm_stale_ready", 32'(cpu_ack), 32'd0);
        check("rm_idle", 32'(mem_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
